lycan_tx_arbiter: RTL and testbench

Merges the outbound packet streams of all `num_peripherals` peripheral slots into the single USB transmit stream. The block sits between the peripheral array and the USB TX FIFO. It arbitrates round-robin among requesting peripherals and stamps the source peripheral address into each 32-bit packet. It drives one registered output word per cycle, and full throughput is sustained when the FIFO does not apply backpressure.

---
 rtl/lycan_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_lycan_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lycan_tx_arbiter.sv
// lycan_tx_arbiter
//   Round-robin merge of all peripheral packet streams into the single USB TX
//   stream. The granted slot index is stamped into the top address bits of each
//   word. tx_valid/tx_data form one output register that refills every cycle
//   while the FIFO accepts.
//
//   Optional feature: define LYCAN_TX_ARB_LOCK_EN to hold the grant on one slot
//   for a whole burst (until a word with periph_last set). Without it,
//   periph_last is ignored and arbitration happens per word.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   periph_valid  : per-slot word valid
//   periph_data   : per-slot word, packed [slot][bit]
//   periph_last   : per-slot end of burst (lock build only)
//   periph_ready  : per-slot accept, one-hot or zero
//   tx_valid      : output word valid
//   tx_data       : output word with stamped source slot
//   tx_ready      : TX FIFO accept
module lycan_tx_arbiter #(
    parameter int num_peripherals      = 8,
    parameter int usb_packet_width     = 32,
    parameter int periph_address_width = $clog2(num_peripherals)
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [num_peripherals-1:0]                        periph_valid,
    input  logic [num_peripherals-1:0][usb_packet_width-1:0] periph_data,
    input  logic [num_peripherals-1:0]                        periph_last,
    output logic [num_peripherals-1:0]                        periph_ready,
    output logic                                              tx_valid,
    output logic [usb_packet_width-1:0]                       tx_data,
    input  logic                                              tx_ready
);
    localparam int AW = periph_address_width;
    localparam int PW = usb_packet_width - periph_address_width;

    logic                        tx_valid_q, tx_valid_d;
    logic [usb_packet_width-1:0] tx_data_q, tx_data_d;
    logic [AW-1:0]               rr_ptr_q, rr_ptr_d;

    logic [AW-1:0] grant;
    logic [AW-1:0] idx;
    logic          grant_vld;
    logic          load;
    logic          xfer;

`ifdef LYCAN_TX_ARB_LOCK_EN
    typedef enum logic {ARB, LOCK} state_e;
    state_e        state_q, state_d;
    logic [AW-1:0] lock_slot_q, lock_slot_d;
`endif

    // Peripheral address bits and (in the default build) periph_last are not
    // part of the datapath; fold them here so they are visibly consumed.
    logic unused_in;
    assign unused_in = ^{periph_last, periph_data};

    // Search from rr_ptr upward. Scanning offsets high-to-low lets the
    // smallest offset win. rr_ptr + i wraps naturally because the slot count
    // is a power of two.
    always_comb begin
        grant     = rr_ptr_q;
        grant_vld = 1'b0;
        idx       = rr_ptr_q;
        for (int i = num_peripherals - 1; i >= 0; i--) begin
            idx = rr_ptr_q + AW'(i);
            if (periph_valid[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
`ifdef LYCAN_TX_ARB_LOCK_EN
        // Mid-burst only the locked slot is eligible, valid or not.
        if (state_q == LOCK) begin
            grant     = lock_slot_q;
            grant_vld = periph_valid[lock_slot_q];
        end
`endif
    end

    always_comb begin
        load         = !tx_valid_q || tx_ready;
        xfer         = load && grant_vld && !rst;
        periph_ready = '0;
        if (xfer) periph_ready[grant] = 1'b1;

        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) tx_valid_d = xfer;
        if (xfer) tx_data_d = {grant, periph_data[grant][PW-1:0]};

`ifdef LYCAN_TX_ARB_LOCK_EN
        state_d     = state_q;
        lock_slot_d = lock_slot_q;
        if (xfer) begin
            if (periph_last[grant]) begin
                state_d  = ARB;
                rr_ptr_d = grant + AW'(1);
            end else begin
                // Pointer stays put while locked; it advances at burst end.
                state_d     = LOCK;
                lock_slot_d = grant;
            end
        end
`else
        if (xfer) rr_ptr_d = grant + AW'(1);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            rr_ptr_q    <= '0;
`ifdef LYCAN_TX_ARB_LOCK_EN
            state_q     <= ARB;
            lock_slot_q <= '0;
`endif
        end else begin
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef LYCAN_TX_ARB_LOCK_EN
            state_q     <= state_d;
            lock_slot_q <= lock_slot_d;
`endif
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_lycan_tx_arbiter.sv
module tb_lycan_tx_arbiter;
    logic              clk;
    logic              rst;
    logic [7:0]        periph_valid;
    logic [7:0][31:0]  periph_data;
    logic [7:0]        periph_last;
    logic [7:0]        periph_ready;
    logic              tx_valid;
    logic [31:0]       tx_data;
    logic              tx_ready;

    logic [31:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    lycan_tx_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .periph_valid (periph_valid),
        .periph_data  (periph_data),
        .periph_last  (periph_last),
        .periph_ready (periph_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] stamp(input logic [2:0] s, input logic [31:0] d);
        return {s, d[28:0]};
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        periph_valid = '0;
        periph_last  = '0;
        tx_ready     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst          = 1'b1;
        periph_valid = '0;
        periph_last  = '0;
        periph_data  = '0;
        tx_ready     = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        periph_valid[3] = 1'b1;
        periph_data[3]  = 32'hFFFF_FFFF;
        exp_q.push_back(32'h7FFF_FFFF);
        @(negedge clk);
        total++; if (periph_ready !== 8'h00) begin bad++; $display("FAIL reset_ready: got %h want 00", periph_ready); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
        total++; if (tx_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", tx_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (periph_ready !== 8'h08) begin bad++; $display("FAIL reset_grant3: got %h want 08", periph_ready); end
        @(posedge clk); #1;
        periph_valid = '0;
        @(negedge clk);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL reset_latency: got %b want 1", tx_valid); end
        if (tx_valid && tx_ready) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL reset_word: got %h want none", tx_data); end
            else begin e = exp_q.pop_front(); if (tx_data !== e) begin bad++; $display("FAIL reset_word: got %h want %h", tx_data, e); end end
        end
        @(posedge clk); #1;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL reset_drain: left %0d want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_all_slots();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) periph_data[i] = $urandom();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++) exp_q.push_back(stamp(3'(i), periph_data[i]));
        periph_valid = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 15) periph_valid = '0;
            @(negedge clk);
            if (c < 16) begin
                total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL all_gap c=%0d: got %b want 1", c, tx_valid); end
            end
            if (tx_valid && tx_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL all_word: got %h want none", tx_data); end
                else begin e = exp_q.pop_front(); if (tx_data !== e) begin bad++; $display("FAIL all_word c=%0d: got %h want %h", c, tx_data, e); end end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL all_drain: left %0d want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_backpressure();
        logic [31:0] e, w2, w5;
        do_reset();
        w2 = 32'hC000_0222;
        w5 = 32'h2000_0555;
        periph_data[2] = w2;
        periph_data[5] = w5;
        exp_q.push_back(stamp(3'd2, w2));
        exp_q.push_back(stamp(3'd5, w5));
        periph_valid = 8'h24;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (tx_valid !== 1'b1 || tx_data !== stamp(3'd2, w2)) begin bad++; $display("FAIL stall_hold k=%0d: got %b/%h want 1/%h", k, tx_valid, tx_data, stamp(3'd2, w2)); end
            total++; if (periph_ready !== 8'h00) begin bad++; $display("FAIL stall_ready k=%0d: got %h want 00", k, periph_ready); end
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        @(negedge clk);
        total++; if (periph_ready !== 8'h20) begin bad++; $display("FAIL stall_next: got %h want 20", periph_ready); end
        if (tx_valid && tx_ready) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL stall_word: got %h want none", tx_data); end
            else begin e = exp_q.pop_front(); if (tx_data !== e) begin bad++; $display("FAIL stall_word: got %h want %h", tx_data, e); end end
        end
        @(posedge clk); #1;
        periph_valid = '0;
        @(negedge clk);
        if (tx_valid && tx_ready) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL stall_word2: got %h want none", tx_data); end
            else begin e = exp_q.pop_front(); if (tx_data !== e) begin bad++; $display("FAIL stall_word2: got %h want %h", tx_data, e); end end
        end
        @(posedge clk); #1;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_drain: left %0d want 0", exp_q.size()); exp_q.delete(); end
    endtask

    // Slot 1 sends a 3-word burst, slot 4 sends two single-word bursts.
    task automatic test_burst();
        logic [31:0] e;
        logic [31:0] d1[3];
        logic [31:0] d4[2];
        logic acc1, acc4;
        int n1, n4;
        d1[0] = 32'h1111_1111; d1[1] = 32'h2222_2222; d1[2] = 32'h3333_3333;
        d4[0] = 32'hE444_4444; d4[1] = 32'h5555_5555;
        do_reset();
`ifdef LYCAN_TX_ARB_LOCK_EN
        exp_q.push_back(stamp(3'd1, d1[0]));
        exp_q.push_back(stamp(3'd1, d1[1]));
        exp_q.push_back(stamp(3'd1, d1[2]));
        exp_q.push_back(stamp(3'd4, d4[0]));
        exp_q.push_back(stamp(3'd4, d4[1]));
`else
        exp_q.push_back(stamp(3'd1, d1[0]));
        exp_q.push_back(stamp(3'd4, d4[0]));
        exp_q.push_back(stamp(3'd1, d1[1]));
        exp_q.push_back(stamp(3'd4, d4[1]));
        exp_q.push_back(stamp(3'd1, d1[2]));
`endif
        n1 = 0; n4 = 0;
        periph_valid[1] = 1'b1; periph_data[1] = d1[0]; periph_last[1] = 1'b0;
        periph_valid[4] = 1'b1; periph_data[4] = d4[0]; periph_last[4] = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            total++; if ((periph_ready & ~periph_valid) !== 8'h00) begin bad++; $display("FAIL burst_rdy_no_vld c=%0d: got %h want 00", c, periph_ready & ~periph_valid); end
            acc1 = periph_valid[1] && periph_ready[1];
            acc4 = periph_valid[4] && periph_ready[4];
            if (tx_valid && tx_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL burst_word c=%0d: got %h want none", c, tx_data); end
                else begin e = exp_q.pop_front(); if (tx_data !== e) begin bad++; $display("FAIL burst_word c=%0d: got %h want %h", c, tx_data, e); end end
            end
            @(posedge clk); #1;
            if (acc1) n1++;
            if (acc4) n4++;
            periph_valid[1] = (n1 < 3);
            if (n1 < 3) begin periph_data[1] = d1[n1]; periph_last[1] = (n1 == 2); end
            periph_valid[4] = (n4 < 2);
            if (n4 < 2) periph_data[4] = d4[n4];
        end
        total++; if (n1 != 3 || n4 != 2) begin bad++; $display("FAIL burst_counts: got %0d/%0d want 3/2", n1, n4); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL burst_drain: left %0d want 0", exp_q.size()); exp_q.delete(); end
        periph_valid = '0;
        periph_last  = '0;
    endtask

`ifdef LYCAN_TX_ARB_LOCK_EN
    task automatic test_lock_reset();
        logic [31:0] e;
        do_reset();
        periph_data[6] = 32'h0666_0001;
        periph_data[0] = 32'hF000_0AAA;
        exp_q.push_back(stamp(3'd6, 32'h0666_0001));
        exp_q.push_back(stamp(3'd0, 32'hF000_0AAA));
        periph_valid = 8'h40;
        @(negedge clk);
        total++; if (periph_ready !== 8'h40) begin bad++; $display("FAIL lockrst_first: got %h want 40", periph_ready); end
        @(posedge clk); #1;
        periph_data[6] = 32'h0666_0002;
        periph_valid   = 8'h41;
        @(negedge clk);
        total++; if (periph_ready !== 8'h40) begin bad++; $display("FAIL lockrst_locked: got %h want 40", periph_ready); end
        if (tx_valid && tx_ready && !rst) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL lockrst_word: got %h want none", tx_data); end
            else begin e = exp_q.pop_front(); if (tx_data !== e) begin bad++; $display("FAIL lockrst_word: got %h want %h", tx_data, e); end end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (periph_ready !== 8'h00) begin bad++; $display("FAIL lockrst_rst_ready: got %h want 00", periph_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL lockrst_dropped: got %b want 0", tx_valid); end
        total++; if (periph_ready !== 8'h01) begin bad++; $display("FAIL lockrst_slot0: got %h want 01", periph_ready); end
        @(posedge clk); #1;
        periph_valid = '0;
        @(negedge clk);
        if (tx_valid && tx_ready && !rst) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL lockrst_word0: got %h want none", tx_data); end
            else begin e = exp_q.pop_front(); if (tx_data !== e) begin bad++; $display("FAIL lockrst_word0: got %h want %h", tx_data, e); end end
        end
        @(posedge clk); #1;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL lockrst_drain: left %0d want 0", exp_q.size()); exp_q.delete(); end
    endtask
`endif

    initial begin
        test_reset();
        test_all_slots();
        test_backpressure();
        test_burst();
`ifdef LYCAN_TX_ARB_LOCK_EN
        test_lock_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
